fetch_stage: RTL and testbench

- IF stage of the pipelined RV32I core with always-untaken branch prediction. Sits directly upstream of the decode control unit.
- Owns the PC, drives the synchronous instruction memory and holds the IF/ID register that feeds instruction fields to decode.
- Always predicts PC+4. EX redirects the PC on a taken branch or jal/jalr. The hazard unit stalls it on load-use.

---
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// IF stage: PC register, synchronous imem address, IF/ID register, always-untaken prediction.
// Optional perf counters under `define FETCH_PERF_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_four,
  output logic [31:0] o_instr,
  output logic        o_insn_vld,
  output logic        o_fetch_err,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_flush_cnt
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, pc_inc;
  logic        load_vld, load_nop, set_err;

  assign pc_inc = pc_q + 32'd4;

  // pc_q tracks the address whose word arrives on i_imem_rdata this cycle
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    o_imem_addr = pc_q;
    load_vld    = 1'b0;
    load_nop    = 1'b0;
    set_err     = 1'b0;
    case (state_q)
      BOOT: begin
        load_nop = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        if (i_redirect) begin
          load_nop = 1'b1;
          if (i_redirect_pc[1:0] == 2'b00) begin
            o_imem_addr = i_redirect_pc;
            pc_d        = i_redirect_pc;
          end else begin
            set_err = 1'b1;
            state_d = HALT;
          end
        end else if (!i_stall) begin
          o_imem_addr = pc_inc;
          pc_d        = pc_inc;
          load_vld    = 1'b1;
        end
      end
      HALT: begin
        load_nop = 1'b1;
      end
      default: begin
        load_nop = 1'b1;
        state_d  = HALT;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // On a flush only the instruction/valid are cleared; the PC fields hold
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_pc        <= RESET_PC;
      o_pc_four   <= RESET_PC + 32'd4;
      o_instr     <= NOP_INSN;
      o_insn_vld  <= 1'b0;
      o_fetch_err <= 1'b0;
    end else begin
      if (load_vld) begin
        o_pc       <= pc_q;
        o_pc_four  <= pc_inc;
        o_instr    <= i_imem_rdata;
        o_insn_vld <= 1'b1;
      end else if (load_nop) begin
        o_instr    <= NOP_INSN;
        o_insn_vld <= 1'b0;
      end
      if (set_err) begin
        o_fetch_err <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;
  logic        flush;

  assign flush = (state_q == RUN) && i_redirect;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (load_vld) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (flush)    flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign o_fetch_cnt = fetch_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`else
  assign o_fetch_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: instruction-stream reference model plus directed scenarios.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, redirect = 1'b0;
  logic [31:0] rpc = '0;
  logic [31:0] imem_addr, rdata = '0, pc, pc_four, instr, fcnt, flcnt;
  logic        vld, err;

  logic        rst_w = 1'b0, zero1 = 1'b0;
  logic [31:0] zero32 = '0;
  logic [31:0] addr_w, rdata_w = '0, pc_w, four_w, instr_w, fcnt_w, flcnt_w;
  logic        vld_w, err_w;

  int n_checks = 0, n_fail = 0;

  // reference model: next instruction address to deliver plus delivery state
  logic [31:0] scramble = '0;
  logic [31:0] m_fetch_pc, m_pc, m_four, m_instr, m_fcnt, m_flcnt, exp_addr, obs_addr;
  logic        m_vld, m_err, addr_chk;
  int          m_bubbles;

  always #5 clk = ~clk;

  fetch_stage dut (
    .i_clk(clk), .i_reset(rst_n), .i_stall(stall), .i_redirect(redirect),
    .i_redirect_pc(rpc), .o_imem_addr(imem_addr), .i_imem_rdata(rdata),
    .o_pc(pc), .o_pc_four(pc_four), .o_instr(instr), .o_insn_vld(vld),
    .o_fetch_err(err), .o_fetch_cnt(fcnt), .o_flush_cnt(flcnt)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .i_clk(clk), .i_reset(rst_w), .i_stall(zero1), .i_redirect(zero1),
    .i_redirect_pc(zero32), .o_imem_addr(addr_w), .i_imem_rdata(rdata_w),
    .o_pc(pc_w), .o_pc_four(four_w), .o_instr(instr_w), .o_insn_vld(vld_w),
    .o_fetch_err(err_w), .o_fetch_cnt(fcnt_w), .o_flush_cnt(flcnt_w)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ scramble;
  endfunction

  function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef FETCH_PERF_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  always @(posedge clk) begin
    rdata   <= mem_word(imem_addr);
    rdata_w <= addr_w;
  end

  task automatic model_reset();
    m_fetch_pc = 32'h0; m_pc = 32'h0; m_four = 32'h4; m_instr = NOP;
    m_vld = 1'b0; m_err = 1'b0; m_bubbles = 1; m_fcnt = '0; m_flcnt = '0;
  endtask

  // drive one cycle, record pre-edge address, advance the model past the edge
  task automatic step(input logic st, input logic rd, input logic [31:0] tgt);
    stall = st; redirect = rd; rpc = tgt;
    addr_chk = 1'b1;
    if (m_err || m_bubbles > 0)  exp_addr = m_fetch_pc;
    else if (rd) begin
      exp_addr = tgt;
      addr_chk = (tgt[1:0] == 2'b00);
    end else if (st)              exp_addr = m_fetch_pc;
    else                          exp_addr = m_fetch_pc + 32'd4;
    #1 obs_addr = imem_addr;
    @(posedge clk);
    #1;
    if (m_err) begin
      m_instr = NOP; m_vld = 1'b0;
    end else if (m_bubbles > 0) begin
      m_bubbles--; m_instr = NOP; m_vld = 1'b0;
    end else if (rd) begin
      m_flcnt++; m_instr = NOP; m_vld = 1'b0;
      if (tgt[1:0] != 2'b00) m_err = 1'b1;
      else m_fetch_pc = tgt;
    end else if (!st) begin
      m_pc = m_fetch_pc; m_four = m_fetch_pc + 32'd4; m_instr = mem_word(m_fetch_pc);
      m_vld = 1'b1; m_fetch_pc = m_fetch_pc + 32'd4; m_fcnt++;
    end
    stall = 1'b0; redirect = 1'b0;
  endtask

  task automatic do_reset();
    stall = 1'b0; redirect = 1'b0; rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (4) step(1'b0, 1'b0, '0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", vld); end
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", pc); end
    n_checks++; if (pc_four !== 32'h4) begin n_fail++; $display("FAIL reset_pc_four: got %h expected 4", pc_four); end
    n_checks++; if (instr !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", instr, NOP); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    n_checks++; if (fcnt !== 32'h0 || flcnt !== 32'h0) begin n_fail++; $display("FAIL reset_cnt: got %h/%h expected 0/0", fcnt, flcnt); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
  endtask

  task automatic test_free_run();
    scramble = '0;
    do_reset();
    step(1'b0, 1'b0, '0);
    n_checks++; if (vld !== 1'b0) begin n_fail++; $display("FAIL boot_vld: got %b expected 0", vld); end
    n_checks++; if (obs_addr !== 32'h0) begin n_fail++; $display("FAIL boot_addr: got %h expected 0", obs_addr); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, '0);
      n_checks++; if (vld !== 1'b1) begin n_fail++; $display("FAIL run_vld[%0d]: got %b expected 1", i, vld); end
      n_checks++; if (pc !== 32'(4 * i)) begin n_fail++; $display("FAIL run_pc[%0d]: got %h expected %h", i, pc, 32'(4 * i)); end
      n_checks++; if (instr !== 32'(4 * i)) begin n_fail++; $display("FAIL run_instr[%0d]: got %h expected %h", i, instr, 32'(4 * i)); end
      n_checks++; if (pc_four !== 32'(4 * i + 4)) begin n_fail++; $display("FAIL run_four[%0d]: got %h expected %h", i, pc_four, 32'(4 * i + 4)); end
      n_checks++; if (obs_addr !== 32'(4 * i + 4)) begin n_fail++; $display("FAIL run_addr[%0d]: got %h expected %h", i, obs_addr, 32'(4 * i + 4)); end
    end
    n_checks++; if (fcnt !== perf(32'd4)) begin n_fail++; $display("FAIL run_fetch_cnt: got %h expected %h", fcnt, perf(32'd4)); end
  endtask

  task automatic test_stall();
    scramble = '0;
    do_reset();
    repeat (4) step(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, '0);
      n_checks++; if (pc !== 32'd8 || vld !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d]: got pc %h vld %b expected pc 8 vld 1", i, pc, vld); end
      n_checks++; if (obs_addr !== 32'd12) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h expected c", i, obs_addr); end
    end
    step(1'b0, 1'b0, '0);
    n_checks++; if (pc !== 32'd12 || instr !== 32'd12) begin n_fail++; $display("FAIL stall_resume: got pc %h instr %h expected c/c", pc, instr); end
    step(1'b0, 1'b0, '0);
    n_checks++; if (pc !== 32'd16) begin n_fail++; $display("FAIL stall_next: got %h expected 10", pc); end
  endtask

  task automatic test_redirect();
    scramble = '0;
    do_reset();
    repeat (4) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h100);
    n_checks++; if (vld !== 1'b0 || instr !== NOP) begin n_fail++; $display("FAIL redir_flush: got vld %b instr %h expected 0/%h", vld, instr, NOP); end
    n_checks++; if (obs_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr: got %h expected 100", obs_addr); end
    step(1'b0, 1'b0, '0);
    n_checks++; if (pc !== 32'h100 || pc_four !== 32'h104 || vld !== 1'b1) begin n_fail++; $display("FAIL redir_target: got %h/%h/%b expected 100/104/1", pc, pc_four, vld); end
    n_checks++; if (instr !== 32'h100) begin n_fail++; $display("FAIL redir_instr: got %h expected 100", instr); end
    step(1'b1, 1'b1, 32'h200);
    n_checks++; if (vld !== 1'b0 || obs_addr !== 32'h200) begin n_fail++; $display("FAIL redir_stall: got vld %b addr %h expected 0/200", vld, obs_addr); end
    n_checks++; if (flcnt !== perf(32'd2)) begin n_fail++; $display("FAIL redir_flush_cnt: got %h expected %h", flcnt, perf(32'd2)); end
    step(1'b0, 1'b0, '0);
    n_checks++; if (pc !== 32'h200 || vld !== 1'b1) begin n_fail++; $display("FAIL redir_stall_target: got %h/%b expected 200/1", pc, vld); end
  endtask

  task automatic test_misaligned();
    scramble = '0;
    do_reset();
    repeat (3) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h102);
    n_checks++; if (err !== 1'b1 || vld !== 1'b0) begin n_fail++; $display("FAIL mis_err: got err %b vld %b expected 1/0", err, vld); end
    for (int i = 0; i < 6; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h40);
      n_checks++; if (err !== 1'b1 || vld !== 1'b0) begin n_fail++; $display("FAIL mis_halt[%0d]: got err %b vld %b expected 1/0", i, err, vld); end
      n_checks++; if (obs_addr !== exp_addr) begin n_fail++; $display("FAIL mis_addr[%0d]: got %h expected %h", i, obs_addr, exp_addr); end
    end
    n_checks++; if (flcnt !== perf(32'd1)) begin n_fail++; $display("FAIL mis_flush_cnt: got %h expected %h", flcnt, perf(32'd1)); end
    do_reset();
    repeat (2) step(1'b0, 1'b0, '0);
    n_checks++; if (err !== 1'b0 || vld !== 1'b1 || pc !== 32'h0) begin n_fail++; $display("FAIL mis_recover: got err %b vld %b pc %h expected 0/1/0", err, vld, pc); end
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    logic        st, rd;
    int          halt_cycles;
    scramble = $urandom;
    do_reset();
    halt_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      st  = ($urandom_range(0, 99) < 30);
      rd  = ($urandom_range(0, 99) < 10);
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 99) < 3) tgt[1:0] = 2'($urandom_range(1, 3));
      step(st, rd, tgt);
      if (addr_chk) begin
        n_checks++; if (obs_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h expected %h", i, obs_addr, exp_addr); end
      end
      n_checks++; if (vld !== m_vld || err !== m_err) begin n_fail++; $display("FAIL rnd_flags[%0d]: got vld %b err %b expected %b/%b", i, vld, err, m_vld, m_err); end
      n_checks++; if (instr !== m_instr) begin n_fail++; $display("FAIL rnd_instr[%0d]: got %h expected %h", i, instr, m_instr); end
      if (m_vld) begin
        n_checks++; if (pc !== m_pc || pc_four !== m_four) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h/%h expected %h/%h", i, pc, pc_four, m_pc, m_four); end
      end
      n_checks++; if (fcnt !== perf(m_fcnt) || flcnt !== perf(m_flcnt)) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %h/%h expected %h/%h", i, fcnt, flcnt, perf(m_fcnt), perf(m_flcnt)); end
      if (m_err) halt_cycles++;
      if (halt_cycles > 4) begin
        halt_cycles = 0;
        scramble = $urandom;
        do_reset();
      end
    end
  endtask

  task automatic test_wrap();
    @(posedge clk);
    #1 rst_w = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (pc_w !== 32'hFFFF_FFF8 || vld_w !== 1'b1 || instr_w !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_0: got %h/%b/%h expected fffffff8/1/fffffff8", pc_w, vld_w, instr_w); end
    @(posedge clk);
    #1;
    n_checks++; if (pc_w !== 32'hFFFF_FFFC || four_w !== 32'h0) begin n_fail++; $display("FAIL wrap_1: got %h/%h expected fffffffc/0", pc_w, four_w); end
    @(posedge clk);
    #1;
    n_checks++; if (pc_w !== 32'h0 || four_w !== 32'h4 || instr_w !== 32'h0 || err_w !== 1'b0) begin n_fail++; $display("FAIL wrap_2: got %h/%h/%h/%b expected 0/4/0/0", pc_w, four_w, instr_w, err_w); end
    n_checks++; if (fcnt_w !== perf(32'd3) || flcnt_w !== 32'h0) begin n_fail++; $display("FAIL wrap_cnt: got %h/%h expected %h/0", fcnt_w, flcnt_w, perf(32'd3)); end
  endtask

  initial begin
    model_reset();
    #2;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_misaligned();
    test_random();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
